// File: rtl/uart_regs.sv
// UART register bank: CTRL/STATUS/BAUD/INT registers plus TX and RX byte FIFOs.
// Define UART_REGS_SCRATCH_EN to map a 32-bit RW SCRATCH register at word index 7.

module uart_regs_fifo #(
  parameter int DEPTH = 16,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    din,
  output logic [7:0]    dout,
  output logic          full,
  output logic          empty,
  output logic          drop,
  output logic [LW-1:0] level
);
  localparam int AW = LW - 1;

  logic [7:0]    mem [DEPTH];
  logic [LW-1:0] wptr_reg;
  logic [LW-1:0] rptr_reg;
  logic          do_push;
  logic          do_pop;

  // Pointers carry a wrap bit so full and empty are distinguishable.
  assign empty   = (wptr_reg == rptr_reg);
  assign full    = (wptr_reg[AW] != rptr_reg[AW]) && (wptr_reg[AW-1:0] == rptr_reg[AW-1:0]);
  assign level   = wptr_reg - rptr_reg;
  assign do_pop  = pop && !empty && !clr;
  assign do_push = push && !clr && (!full || do_pop);
  assign drop    = push && !clr && full && !do_pop;
  assign dout    = mem[rptr_reg[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_reg <= '0;
      rptr_reg <= '0;
    end else if (clr) begin
      wptr_reg <= '0;
      rptr_reg <= '0;
    end else begin
      if (do_push) wptr_reg <= wptr_reg + LW'(1);
      if (do_pop)  rptr_reg <= rptr_reg + LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr_reg[AW-1:0]] <= din;
  end
endmodule

module uart_regs #(
  parameter int          DATA_WIDTH     = 32,
  parameter int          REG_ADDR_WIDTH = 4,
  parameter int          FIFO_DEPTH     = 16,
  parameter logic [15:0] BAUD_RESET     = 16'd27
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [REG_ADDR_WIDTH-1:0] reg_addr,
  input  logic [DATA_WIDTH-1:0]     reg_wdata,
  input  logic [3:0]                reg_wstrb,
  input  logic                      reg_wen,
  input  logic                      reg_ren,
  output logic [DATA_WIDTH-1:0]     reg_rdata,
  output logic                      reg_error,
  output logic [7:0]                tx_data,
  output logic                      tx_valid,
  input  logic                      tx_ready,
  input  logic [7:0]                rx_data,
  input  logic                      rx_valid,
  output logic [15:0]               baud_div,
  output logic                      tx_en,
  output logic                      rx_en,
  output logic                      irq
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  localparam logic [REG_ADDR_WIDTH-1:0] A_CTRL = REG_ADDR_WIDTH'(0);
  localparam logic [REG_ADDR_WIDTH-1:0] A_STAT = REG_ADDR_WIDTH'(1);
  localparam logic [REG_ADDR_WIDTH-1:0] A_BAUD = REG_ADDR_WIDTH'(2);
  localparam logic [REG_ADDR_WIDTH-1:0] A_TXD  = REG_ADDR_WIDTH'(3);
  localparam logic [REG_ADDR_WIDTH-1:0] A_RXD  = REG_ADDR_WIDTH'(4);
  localparam logic [REG_ADDR_WIDTH-1:0] A_IEN  = REG_ADDR_WIDTH'(5);
  localparam logic [REG_ADDR_WIDTH-1:0] A_IST  = REG_ADDR_WIDTH'(6);

  genvar gi;

  logic                      wen_q_reg;
  logic                      ren_q_reg;
  logic [REG_ADDR_WIDTH-1:0] ren_addr_reg;
  logic [1:0]                ctrl_reg;
  logic [15:0]               baud_reg;
  logic [15:0]               baud_next;
  logic [3:0]                int_en_reg;
  logic                      rx_ovr_reg;
  logic                      tx_ovf_reg;
  logic                      irq_reg;

  logic          wr_fire, wr_b0;
  logic          tx_clr, rx_clr, tx_push, tx_pop, rx_push, rx_pop;
  logic          tx_full, tx_empty, tx_drop, rx_full, rx_empty, rx_drop;
  logic [LW-1:0] tx_level, rx_level;
  logic [7:0]    rx_head;
  logic [3:0]    int_stat;
  logic          unused_bits;

  // A held reg_wen acts once; RX pops when a read of RX_DATA ends.
  assign wr_fire = reg_wen && !wen_q_reg;
  assign wr_b0   = wr_fire && reg_wstrb[0];
  assign tx_clr  = wr_b0 && (reg_addr == A_CTRL) && reg_wdata[2];
  assign rx_clr  = wr_b0 && (reg_addr == A_CTRL) && reg_wdata[3];
  assign tx_push = wr_b0 && (reg_addr == A_TXD);
  assign tx_valid = ctrl_reg[0] && !tx_empty;
  assign tx_pop  = tx_valid && tx_ready;
  assign rx_push = rx_valid && ctrl_reg[1];
  assign rx_pop  = ren_q_reg && !reg_ren && (ren_addr_reg == A_RXD);

  assign int_stat = {tx_ovf_reg, rx_ovr_reg, tx_empty, !rx_empty};
  assign baud_div = baud_reg;
  assign tx_en    = ctrl_reg[0];
  assign rx_en    = ctrl_reg[1];
  assign irq      = irq_reg;
  assign unused_bits = ^{reg_wdata, reg_wstrb};

  uart_regs_fifo #(.DEPTH(FIFO_DEPTH), .LW(LW)) u_tx_fifo (
    .clk(clk), .rst_n(rst_n), .clr(tx_clr), .push(tx_push), .pop(tx_pop),
    .din(reg_wdata[7:0]), .dout(tx_data), .full(tx_full), .empty(tx_empty),
    .drop(tx_drop), .level(tx_level)
  );

  uart_regs_fifo #(.DEPTH(FIFO_DEPTH), .LW(LW)) u_rx_fifo (
    .clk(clk), .rst_n(rst_n), .clr(rx_clr), .push(rx_push), .pop(rx_pop),
    .din(rx_data), .dout(rx_head), .full(rx_full), .empty(rx_empty),
    .drop(rx_drop), .level(rx_level)
  );

  for (gi = 0; gi < 2; gi++) begin : g_baud
    assign baud_next[gi*8 +: 8] = (wr_fire && (reg_addr == A_BAUD) && reg_wstrb[gi])
                                  ? reg_wdata[gi*8 +: 8] : baud_reg[gi*8 +: 8];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wen_q_reg    <= 1'b0;
      ren_q_reg    <= 1'b0;
      ren_addr_reg <= '0;
      ctrl_reg     <= '0;
      baud_reg     <= BAUD_RESET;
      int_en_reg   <= '0;
      rx_ovr_reg   <= 1'b0;
      tx_ovf_reg   <= 1'b0;
      irq_reg      <= 1'b0;
    end else begin
      wen_q_reg <= reg_wen;
      ren_q_reg <= reg_ren;
      if (reg_ren) ren_addr_reg <= reg_addr;
      irq_reg  <= |(int_stat & int_en_reg);
      baud_reg <= baud_next;
      if (wr_b0 && (reg_addr == A_CTRL)) ctrl_reg   <= reg_wdata[1:0];
      if (wr_b0 && (reg_addr == A_IEN))  int_en_reg <= reg_wdata[3:0];
      // Sticky sets take precedence over a same-cycle W1C.
      if (rx_drop)                                          rx_ovr_reg <= 1'b1;
      else if (wr_b0 && (reg_addr == A_IST) && reg_wdata[2]) rx_ovr_reg <= 1'b0;
      if (tx_drop)                                          tx_ovf_reg <= 1'b1;
      else if (wr_b0 && (reg_addr == A_IST) && reg_wdata[3]) tx_ovf_reg <= 1'b0;
    end
  end

`ifdef UART_REGS_SCRATCH_EN
  localparam logic [REG_ADDR_WIDTH-1:0] A_SCR = REG_ADDR_WIDTH'(7);

  logic [DATA_WIDTH-1:0] scratch_reg;
  logic [DATA_WIDTH-1:0] scratch_next;

  for (gi = 0; gi < 4; gi++) begin : g_scratch
    assign scratch_next[gi*8 +: 8] = (wr_fire && (reg_addr == A_SCR) && reg_wstrb[gi])
                                     ? reg_wdata[gi*8 +: 8] : scratch_reg[gi*8 +: 8];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) scratch_reg <= '0;
    else        scratch_reg <= scratch_next;
  end
`endif

  always_comb begin
    reg_rdata = '0;
    reg_error = 1'b0;
    case (reg_addr)
      A_CTRL: reg_rdata[1:0] = ctrl_reg;
      A_STAT: begin
        reg_rdata[3:0]      = {rx_empty, rx_full, tx_empty, tx_full};
        reg_rdata[8 +: LW]  = tx_level;
        reg_rdata[16 +: LW] = rx_level;
      end
      A_BAUD: reg_rdata[15:0] = baud_reg;
      A_TXD:  reg_rdata = '0;
      A_RXD: begin
        reg_rdata[31] = rx_empty;
        if (!rx_empty) reg_rdata[7:0] = rx_head;
      end
      A_IEN:  reg_rdata[3:0] = int_en_reg;
      A_IST:  reg_rdata[3:0] = int_stat;
`ifdef UART_REGS_SCRATCH_EN
      A_SCR:  reg_rdata = scratch_reg;
`endif
      default: reg_error = 1'b1;
    endcase
  end
endmodule

// File: tb/tb_uart_regs.sv
// Randomized bench for uart_regs: queue-based model checked every cycle, plus directed literal checks.
// Honours UART_REGS_SCRATCH_EN the same way as the design.

module tb_uart_regs;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  reg_addr = '0;
  logic [31:0] reg_wdata = '0;
  logic [3:0]  reg_wstrb = '0;
  logic        reg_wen = 1'b0;
  logic        reg_ren = 1'b0;
  logic [31:0] reg_rdata;
  logic        reg_error;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic [15:0] baud_div;
  logic        tx_en, rx_en, irq;

  logic cmp_on = 1'b0;
  logic rand_on = 1'b0;
  int   n_total = 0;
  int   n_pass = 0;

  // Behavioural model state
  logic [7:0]  tx_q[$];
  logic [7:0]  rx_q[$];
  logic [1:0]  m_ctrl;
  logic [15:0] m_baud;
  logic [3:0]  m_inten;
  logic        m_rxovr, m_txovf, m_irq;
  logic [31:0] m_scratch;
  logic        p_wen, p_ren;
  logic [3:0]  p_raddr;

  always #5 clk = ~clk;

  uart_regs #(
    .DATA_WIDTH(32), .REG_ADDR_WIDTH(4), .FIFO_DEPTH(DEPTH), .BAUD_RESET(16'd27)
  ) dut (
    .clk(clk), .rst_n(rst_n), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_wstrb(reg_wstrb), .reg_wen(reg_wen), .reg_ren(reg_ren),
    .reg_rdata(reg_rdata), .reg_error(reg_error), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data),
    .rx_valid(rx_valid), .baud_div(baud_div), .tx_en(tx_en), .rx_en(rx_en),
    .irq(irq)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    tx_q.delete();
    rx_q.delete();
    m_ctrl = '0; m_baud = 16'd27; m_inten = '0;
    m_rxovr = 1'b0; m_txovf = 1'b0; m_irq = 1'b0; m_scratch = '0;
    p_wen = 1'b0; p_ren = 1'b0; p_raddr = '0;
  endtask

  function automatic logic [31:0] m_rdata(input logic [3:0] a);
    int tl, rl;
    tl = tx_q.size();
    rl = rx_q.size();
    case (a)
      4'd0: return {30'b0, m_ctrl};
      4'd1: return {8'b0, 8'(rl), 8'(tl), 4'b0, rl == 0, rl == DEPTH, tl == 0, tl == DEPTH};
      4'd2: return {16'b0, m_baud};
      4'd4: return (rl == 0) ? 32'h8000_0000 : {24'b0, rx_q[0]};
      4'd5: return {28'b0, m_inten};
      4'd6: return {28'b0, m_txovf, m_rxovr, tl == 0, rl != 0};
`ifdef UART_REGS_SCRATCH_EN
      4'd7: return m_scratch;
`endif
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic m_error(input logic [3:0] a);
`ifdef UART_REGS_SCRATCH_EN
    return a >= 4'd8;
`else
    return a >= 4'd7;
`endif
  endfunction

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_step();
    logic [31:0] ist;
    logic irq_n, wr, b0, clr_tx, clr_rx, pop_tx, pop_rx, push_rx, set_rx, set_tx;
    if (!rst_n) begin
      model_reset();
      return;
    end
    ist     = m_rdata(4'd6);
    irq_n   = |(ist[3:0] & m_inten);
    wr      = reg_wen && !p_wen;
    b0      = wr && reg_wstrb[0];
    clr_tx  = b0 && reg_addr == 4'd0 && reg_wdata[2];
    clr_rx  = b0 && reg_addr == 4'd0 && reg_wdata[3];
    pop_tx  = m_ctrl[0] && tx_q.size() != 0 && tx_ready;
    pop_rx  = p_ren && !reg_ren && p_raddr == 4'd4 && rx_q.size() != 0;
    push_rx = rx_valid && m_ctrl[1];
    set_rx  = 1'b0;
    set_tx  = 1'b0;
    if (clr_tx) tx_q.delete();
    else begin
      if (pop_tx) void'(tx_q.pop_front());
      if (b0 && reg_addr == 4'd3) begin
        if (tx_q.size() < DEPTH) tx_q.push_back(reg_wdata[7:0]);
        else set_tx = 1'b1;
      end
    end
    if (clr_rx) rx_q.delete();
    else begin
      if (pop_rx) void'(rx_q.pop_front());
      if (push_rx) begin
        if (rx_q.size() < DEPTH) rx_q.push_back(rx_data);
        else set_rx = 1'b1;
      end
    end
    if (b0 && reg_addr == 4'd6 && reg_wdata[2]) m_rxovr = 1'b0;
    if (b0 && reg_addr == 4'd6 && reg_wdata[3]) m_txovf = 1'b0;
    if (set_rx) m_rxovr = 1'b1;
    if (set_tx) m_txovf = 1'b1;
    if (b0 && reg_addr == 4'd0) m_ctrl = reg_wdata[1:0];
    if (b0 && reg_addr == 4'd5) m_inten = reg_wdata[3:0];
    if (wr && reg_addr == 4'd2) begin
      if (reg_wstrb[0]) m_baud[7:0]  = reg_wdata[7:0];
      if (reg_wstrb[1]) m_baud[15:8] = reg_wdata[15:8];
    end
`ifdef UART_REGS_SCRATCH_EN
    if (wr && reg_addr == 4'd7)
      for (int b = 0; b < 4; b++)
        if (reg_wstrb[b]) m_scratch[b*8 +: 8] = reg_wdata[b*8 +: 8];
`endif
    p_wen = reg_wen;
    p_ren = reg_ren;
    if (reg_ren) p_raddr = reg_addr;
    m_irq = irq_n;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Every-cycle comparison of all DUT outputs against the model.
  initial forever begin
    logic exp_valid;
    @(negedge clk);
    if (cmp_on) begin
      check("rdata", reg_rdata, m_rdata(reg_addr));
      check("reg_error", 32'(reg_error), 32'(m_error(reg_addr)));
      exp_valid = m_ctrl[0] && tx_q.size() != 0;
      check("tx_valid", 32'(tx_valid), 32'(exp_valid));
      if (exp_valid) check("tx_data", 32'(tx_data), 32'(tx_q[0]));
      check("baud_div", 32'(baud_div), 32'(m_baud));
      check("tx_en/rx_en", 32'({tx_en, rx_en}), 32'({m_ctrl[0], m_ctrl[1]}));
      check("irq", 32'(irq), 32'(m_irq));
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rand_on) begin
      rx_valid = ($urandom_range(0, 3) == 0);
      rx_data  = 8'($urandom);
      tx_ready = ($urandom_range(0, 1) == 1);
    end
  end

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s, input int hold);
    @(posedge clk);
    #1;
    reg_addr = a; reg_wdata = d; reg_wstrb = s; reg_wen = 1'b1;
    repeat (hold) @(posedge clk);
    #1;
    reg_wen = 1'b0;
    $display("wr  idx=%0d data=0x%08h strb=0x%h hold=%0d", a, d, s, hold);
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d, output logic e);
    @(posedge clk);
    #1;
    reg_addr = a; reg_ren = 1'b1;
    @(negedge clk);
    d = reg_rdata;
    e = reg_error;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reg_ren = 1'b0;
    $display("rd  idx=%0d data=0x%08h err=%0d", a, d, e);
  endtask

  task automatic rx_pulse(input logic [7:0] b);
    @(posedge clk);
    #1;
    rx_data = b; rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0; reg_wen = 1'b0; reg_ren = 1'b0; reg_addr = 4'd2;
    model_reset();
    #1;
    check("async rst baud rdata", reg_rdata, 32'h0000_001B);
    check("async rst tx_valid", 32'(tx_valid), 32'd0);
    check("async rst irq", 32'(irq), 32'd0);
    check("async rst ctrl", 32'({tx_en, rx_en}), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    $display("rst asserted mid-operation");
  endtask

  initial begin
    logic [31:0] d, wd;
    logic        e;
    logic [3:0]  a;
    int          op;
    model_reset();
    #2;
    rst_n = 1'b0;
    model_reset();
    cmp_on = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    bus_read(4'd2, d, e);
    check("reset BAUD_DIV", d, 32'h0000_001B);
    bus_read(4'd1, d, e);
    check("reset STATUS", d, 32'h0000_000A);

    // TX fill past full with the core stalled, then drain.
    bus_write(4'd0, 32'h1, 4'hF, 1);
    for (int i = 0; i < 17; i++) bus_write(4'd3, 32'(i), 4'h1, 1);
    bus_read(4'd1, d, e);
    check("tx full STATUS", d, 32'h0000_1009);
    bus_read(4'd6, d, e);
    check("tx_ovf INT_STAT", d, 32'h0000_0008);
    @(posedge clk);
    #1;
    tx_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("tx drain valid", 32'(tx_valid), 32'd1);
      check("tx drain data", 32'(tx_data), 32'(i));
    end
    @(posedge clk);
    #1;
    tx_ready = 1'b0;
    bus_write(4'd6, 32'h8, 4'h1, 1);

    // Held write strobe produces one push.
    bus_read(4'd1, d, e);
    check("status before held write", d, 32'h0000_000A);
    bus_write(4'd3, 32'h41, 4'h1, 5);
    bus_read(4'd1, d, e);
    check("held write single push", d, 32'h0000_0108);
    bus_write(4'd0, 32'h5, 4'h1, 1);

    // RX receive and read-pop.
    bus_write(4'd0, 32'h2, 4'h1, 1);
    rx_pulse(8'h55);
    rx_pulse(8'hAA);
    bus_read(4'd4, d, e);
    check("rx read 1", d, 32'h0000_0055);
    bus_read(4'd4, d, e);
    check("rx read 2", d, 32'h0000_00AA);
    bus_read(4'd4, d, e);
    check("rx read empty", d, 32'h8000_0000);
    bus_read(4'd1, d, e);
    check("status after empty read", d, 32'h0000_000A);

    // RX overrun interrupt and W1C.
    bus_write(4'd5, 32'h4, 4'h1, 1);
    for (int i = 0; i < 16; i++) rx_pulse(8'(i + 1));
    @(posedge clk);
    #1;
    reg_addr = 4'd6;
    @(negedge clk);
    check("int_stat before ovr", reg_rdata, 32'h0000_0003);
    check("irq before ovr", 32'(irq), 32'd0);
    rx_pulse(8'hEE);
    @(negedge clk);
    check("int_stat rx_ovr set", reg_rdata, 32'h0000_0007);
    check("irq same cycle as ovr", 32'(irq), 32'd0);
    @(negedge clk);
    check("irq one cycle after ovr", 32'(irq), 32'd1);
    bus_write(4'd6, 32'h4, 4'h1, 1);
    @(negedge clk);
    check("int_stat after W1C", reg_rdata, 32'h0000_0003);
    check("irq lag after W1C", 32'(irq), 32'd1);
    @(negedge clk);
    check("irq cleared", 32'(irq), 32'd0);
    bus_write(4'd0, 32'hA, 4'h1, 1);

    // Unmapped space and the optional scratch register.
    bus_read(4'd9, d, e);
    check("idx9 rdata", d, 32'h0);
    check("idx9 error", 32'(e), 32'd1);
`ifdef UART_REGS_SCRATCH_EN
    bus_write(4'd7, 32'hDEAD_BEEF, 4'h3, 1);
    bus_read(4'd7, d, e);
    check("scratch strobed", d, 32'h0000_BEEF);
    check("scratch error", 32'(e), 32'd0);
`else
    bus_write(4'd7, 32'hDEAD_BEEF, 4'h3, 1);
    bus_read(4'd7, d, e);
    check("idx7 rdata", d, 32'h0);
    check("idx7 error", 32'(e), 32'd1);
`endif

    // Random traffic with a mid-run asynchronous reset.
    rand_on = 1'b1;
    for (int k = 0; k < 1600; k++) begin
      if (k == 800) do_reset();
      op = $urandom_range(0, 9);
      if (op < 4) begin
        a  = ($urandom_range(0, 3) == 0) ? 4'd3 : 4'($urandom_range(0, 15));
        wd = $urandom;
        if (a == 4'd0) begin
          wd[3:2] = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00;
          wd[1:0] = ($urandom_range(0, 4) == 0) ? 2'($urandom) : 2'b11;
        end
        bus_write(a, wd, 4'($urandom), $urandom_range(1, 3));
      end else if (op < 7) begin
        a = ($urandom_range(0, 1) == 0) ? 4'd4 : 4'($urandom_range(0, 15));
        bus_read(a, d, e);
      end else begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
      end
    end
    rand_on = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/uart_regs.md
Name: uart_regs

Overview:
- UART register bank sitting directly downstream of the AXI-Lite slave interface's register port. It consumes reg_addr, reg_wdata, reg_wstrb, reg_wen and reg_ren, and returns reg_rdata and reg_error.
- Holds the control and status registers, the baud divisor and the interrupt logic.
- Contains a TX FIFO feeding the UART transmit core and an RX FIFO filled by the UART receive core.

Parameters:
- DATA_WIDTH, 32, register data width; fixed at 32.
- REG_ADDR_WIDTH, 4, word-index address width.
- FIFO_DEPTH, 16, entries per FIFO; power of two, minimum 2.
- BAUD_RESET, 16'd27, reset value of BAUD_DIV.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active-low
- reg_addr  in  REG_ADDR_WIDTH  word index
- reg_wdata  in  32  write data
- reg_wstrb  in  4  byte strobes
- reg_wen  in  1  write request; level, may stay high for several cycles
- reg_ren  in  1  read request; level, high for 2 cycles per read
- reg_rdata  out  32  combinational read data for reg_addr
- reg_error  out  1  combinational; high when reg_addr is unmapped
- tx_data  out  8  TX FIFO head
- tx_valid  out  1  TX FIFO not empty and CTRL.tx_en set
- tx_ready  in  1  core pops the TX head when tx_valid && tx_ready
- rx_data  in  8  received byte
- rx_valid  in  1  one-cycle push strobe; no backpressure
- baud_div  out  16  BAUD_DIV register
- tx_en  out  1  CTRL[0]
- rx_en  out  1  CTRL[1]
- irq  out  1  registered interrupt, level

Behaviour:
- Reset values: all registers 0 except BAUD_DIV = BAUD_RESET; FIFOs empty; irq = 0; tx_valid = 0; reg_rdata follows the reset register values.
- Write strobe: a write acts once, in the cycle where reg_wen is high and reg_wen_q (reg_wen delayed one cycle) is low. A level reg_wen held high for N cycles produces exactly one write.
- Read side effect: RX pop occurs on the falling edge of reg_ren, i.e. reg_ren_q && !reg_ren. It uses the index latched while reg_ren was high, so it follows data capture by 1 cycle.
- RW registers honour reg_wstrb per byte lane.
- Register map (word index):
  - 0 CTRL RW: [0] tx_en, [1] rx_en. [2] tx_clr and [3] rx_clr are self-clearing; writing 1 empties that FIFO in the write cycle; they always read 0.
  - 1 STATUS RO: [0] tx_full, [1] tx_empty, [2] rx_full, [3] rx_empty, [15:8] tx_level, [23:16] rx_level.
  - 2 BAUD_DIV RW [15:0]; upper bits read 0.
  - 3 TX_DATA WO: if wstrb[0], push wdata[7:0]. If the FIFO is full, the byte is dropped and INT_STAT.tx_ovf is set. Reads return 0.
  - 4 RX_DATA RO: [7:0] head byte, [31] = rx_empty. Read pops only if the FIFO is non-empty. Reading an empty FIFO returns 0x8000_0000 and does not pop.
  - 5 INT_EN RW [3:0].
  - 6 INT_STAT: [0] rx_avail (level, = !rx_empty), [1] tx_empty (level), [2] rx_ovr (sticky, W1C), [3] tx_ovf (sticky, W1C). Writes to bits [1:0] are ignored.
  - 7–15 unmapped: reg_error = 1, read 0, writes ignored.
- irq <= |(INT_STAT[3:0] & INT_EN[3:0]), registered, 1-cycle latency.
- FIFOs: read/write pointers carry one extra wrap bit; full when the MSBs differ and the remaining bits are equal. Level width is clog2(FIFO_DEPTH)+1.
- RX push: accepted when rx_valid && rx_en. If the FIFO is full with no pop that cycle, the byte is dropped and rx_ovr is set. When rx_en = 0, rx_valid is ignored.
- Simultaneous events:
  - Push and pop in the same cycle on a full FIFO: both occur, level unchanged, no overflow flag.
  - Push and pop on an empty FIFO: push only.
  - Clear has priority over a same-cycle push/pop.
  - A sticky set and a W1C clear in the same cycle: the set wins.
- Asynchronous reset mid-operation: all state returns to reset values immediately.

Optional Feature:
- UART_REGS_SCRATCH_EN defined: index 7 is SCRATCH, RW 32-bit with reset value 0, byte strobes honoured, reg_error = 0 at that index.
- Not defined: index 7 is unmapped, same as 8–15.

Test Plan:
- Reset, then read index 2 -> 0x0000_001B. Read index 1 -> 0x0000_000A (tx_empty, rx_empty).
- CTRL = 0x1, hold tx_ready = 0, write TX_DATA 17 times with 0x00..0x10 -> STATUS tx_level = 16, tx_full = 1. INT_STAT = 0x8 (tx_ovf set, tx_empty 0). Then raise tx_ready -> tx_data sequence 0x00..0x0F.
- Hold reg_wen high 5 cycles on TX_DATA 0x41 -> tx_level increments by exactly 1.
- CTRL = 0x2, pulse rx_valid with 0x55 then 0xAA:
  - Read RX_DATA -> 0x55; then -> 0xAA.
  - Third read -> 0x8000_0000 with no level change.
- INT_EN = 0x4, push 17 RX bytes -> irq = 1 one cycle after rx_ovr is set. Write INT_STAT = 0x4 -> rx_ovr clears, irq = 0 next cycle.
- Read index 9 -> reg_error = 1, rdata 0. Index 7 -> reg_error = 1 without UART_REGS_SCRATCH_EN. With it, write 0xDEADBEEF with wstrb 0x3 -> readback 0x0000BEEF.
